// File: rtl/blink_sequencer_if.sv
// Bundle of the LED sequencer's control/status signals.
//
// Handshake: i_start is a request that the sequencer accepts only while it
// is idle (o_busy low, not in its one-cycle completion state); a request
// made at any other time is dropped, not queued. i_stop aborts a running
// sequence. i_tick is a single-cycle event from the upstream timeout counter.
//
// Signals:
//   i_tick     timeout pulse, one clock wide
//   i_start    start request (accepted in idle only)
//   i_stop     abort request
//   i_mode     LED pattern select
//   i_on_len   ON phase length in ticks (0 acts as 1)
//   i_off_len  OFF phase length in ticks (0 acts as 1)
//   i_reps     ON/OFF cycles to run (0 = run until stopped)
//   o_led      LED drive
//   o_busy     high while in an ON or OFF phase
//   o_done     one-cycle pulse on normal completion
//   dbg_state  current sequencer state, for observation only
// Modports: master drives the requests, slave is the sequencer.
interface blink_sequencer_if #(
    parameter int LED_W = 8,
    parameter int LEN_W = 4,
    parameter int REP_W = 4
);
    logic             i_tick;
    logic             i_start;
    logic             i_stop;
    logic [1:0]       i_mode;
    logic [LEN_W-1:0] i_on_len;
    logic [LEN_W-1:0] i_off_len;
    logic [REP_W-1:0] i_reps;
    logic [LED_W-1:0] o_led;
    logic             o_busy;
    logic             o_done;
    logic [1:0]       dbg_state;

    modport master (
        output i_tick, i_start, i_stop, i_mode, i_on_len, i_off_len, i_reps,
        input  o_led, o_busy, o_done, dbg_state
    );

    modport slave (
        input  i_tick, i_start, i_stop, i_mode, i_on_len, i_off_len, i_reps,
        output o_led, o_busy, o_done, dbg_state
    );
endinterface

// File: rtl/blink_sequencer.sv
// ON/OFF LED sequencer driven by an upstream timeout tick.
//
// Counts ticks through an ON phase and an OFF phase, repeats for a
// programmable number of cycles (or forever), and shows one of three LED
// patterns. All outputs are registered and change on the same edge as the
// state transition.
//
// Ports:
//   i_clk  system clock
//   i_rst  asynchronous active-high reset
//   bus    blink_sequencer_if.slave (tick, start/stop, parameters, LED
//          drive, busy/done status, debug state)
module blink_sequencer #(
    parameter int LED_W = 8,
    parameter int LEN_W = 4,
    parameter int REP_W = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    blink_sequencer_if.slave   bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ON   = 2'd1;
    localparam logic [1:0] ST_OFF  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [1:0] MODE_ALL  = 2'd0;
    localparam logic [1:0] MODE_WALK = 2'd1;
    localparam logic [1:0] MODE_HALF = 2'd2;

    localparam logic [LED_W-1:0] PAT_ALL  = '1;
    localparam logic [LED_W-1:0] PAT_WALK = LED_W'(1);
    localparam logic [LED_W-1:0] PAT_HALF = {{(LED_W/2){1'b0}}, {(LED_W/2){1'b1}}};

    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
    localparam logic [REP_W-1:0] REP_ONE = REP_W'(1);

    logic [1:0]       state;
    logic [LEN_W-1:0] tick_cnt;
    logic [REP_W-1:0] rep_cnt;
    logic [LED_W-1:0] pattern;
    logic [1:0]       mode_q;
    logic [LEN_W-1:0] on_len_q;
    logic [LEN_W-1:0] off_len_q;
    logic [REP_W-1:0] reps_q;
    logic [LED_W-1:0] led_q;
    logic             busy_q;
    logic             done_q;

    logic [1:0]       mode_eff;
    logic [LEN_W-1:0] on_len_eff;
    logic [LEN_W-1:0] off_len_eff;
    logic [LED_W-1:0] init_pat;
    logic [LED_W-1:0] next_pat;
    logic [LED_W-1:0] off_led;
    logic [REP_W-1:0] rep_next;
    logic             on_end;
    logic             off_end;
    logic             last_rep;

    always_comb begin
        // Mode 3 aliases mode 0; zero lengths are stored as 1 so the
        // terminal-count compare below never underflows.
        mode_eff    = (bus.i_mode == 2'd3) ? MODE_ALL : bus.i_mode;
        on_len_eff  = (bus.i_on_len  == '0) ? LEN_ONE : bus.i_on_len;
        off_len_eff = (bus.i_off_len == '0) ? LEN_ONE : bus.i_off_len;

        case (mode_eff)
            MODE_WALK: init_pat = PAT_WALK;
            MODE_HALF: init_pat = PAT_HALF;
            default:   init_pat = PAT_ALL;
        endcase

        // Walking mode rotates left, MSB wrapping into the LSB.
        next_pat = (mode_q == MODE_WALK) ? {pattern[LED_W-2:0], pattern[LED_W-1]} : pattern;
        off_led  = (mode_q == MODE_HALF) ? ~pattern : '0;

        on_end   = bus.i_tick && (tick_cnt == (on_len_q  - LEN_ONE));
        off_end  = bus.i_tick && (tick_cnt == (off_len_q - LEN_ONE));
        rep_next = rep_cnt + REP_ONE;
        // reps of zero means continuous: the counter wraps and never ends it.
        last_rep = (reps_q != '0) && (rep_next == reps_q);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= ST_IDLE;
            tick_cnt  <= '0;
            rep_cnt   <= '0;
            pattern   <= '0;
            mode_q    <= '0;
            on_len_q  <= '0;
            off_len_q <= '0;
            reps_q    <= '0;
            led_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.i_start && !bus.i_stop) begin
                        mode_q    <= mode_eff;
                        on_len_q  <= on_len_eff;
                        off_len_q <= off_len_eff;
                        reps_q    <= bus.i_reps;
                        pattern   <= init_pat;
                        led_q     <= init_pat;
                        tick_cnt  <= '0;
                        rep_cnt   <= '0;
                        busy_q    <= 1'b1;
                        state     <= ST_ON;
                    end else begin
                        led_q  <= '0;
                        busy_q <= 1'b0;
                    end
                end

                ST_ON: begin
                    // Stop wins over a tick landing in the same cycle.
                    if (bus.i_stop) begin
                        led_q    <= '0;
                        busy_q   <= 1'b0;
                        tick_cnt <= '0;
                        state    <= ST_IDLE;
                    end else if (on_end) begin
                        tick_cnt <= '0;
                        led_q    <= off_led;
                        state    <= ST_OFF;
                    end else if (bus.i_tick) begin
                        tick_cnt <= tick_cnt + LEN_ONE;
                    end
                end

                ST_OFF: begin
                    if (bus.i_stop) begin
                        led_q    <= '0;
                        busy_q   <= 1'b0;
                        tick_cnt <= '0;
                        state    <= ST_IDLE;
                    end else if (off_end) begin
                        tick_cnt <= '0;
                        rep_cnt  <= rep_next;
                        if (last_rep) begin
                            led_q  <= '0;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            state  <= ST_DONE;
                        end else begin
                            pattern <= next_pat;
                            led_q   <= next_pat;
                            state   <= ST_ON;
                        end
                    end else if (bus.i_tick) begin
                        tick_cnt <= tick_cnt + LEN_ONE;
                    end
                end

                ST_DONE: begin
                    led_q  <= '0;
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end

                default: begin
                    led_q  <= '0;
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.o_led     = led_q;
    assign bus.o_busy    = busy_q;
    assign bus.o_done    = done_q;
    assign bus.dbg_state = state;

endmodule

// File: tb/tb_blink_sequencer.sv
// Testbench for blink_sequencer: directed scenarios plus randomized
// sequences, every cycle compared against a tick-count reference model.
module tb_blink_sequencer;
    localparam int LED_W = 8;
    localparam int LEN_W = 4;
    localparam int REP_W = 4;

    // ---------------- clock / reset ----------------
    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    always #5 i_clk = ~i_clk;

    blink_sequencer_if #(.LED_W(LED_W), .LEN_W(LEN_W), .REP_W(REP_W)) bus ();

    blink_sequencer #(.LED_W(LED_W), .LEN_W(LEN_W), .REP_W(REP_W)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    // ---------------- reference model ----------------
    // A running sequence is described only by how many ticks it has
    // consumed; the phase, cycle index and pattern are derived from that.
    bit m_active  = 0;
    bit m_in_done = 0;
    int m_t       = 0;
    int m_mode    = 0;
    int m_on      = 1;
    int m_off     = 1;
    int m_reps    = 0;

    function automatic logic [LED_W-1:0] exp_led();
        int p, k, pos;
        logic [LED_W-1:0] pat;
        if (!m_active) return '0;
        p   = m_on + m_off;
        k   = m_t / p;
        pos = m_t % p;
        case (m_mode)
            1:       pat = LED_W'(1) << (k % LED_W);
            2:       pat = LED_W'((1 << (LED_W / 2)) - 1);
            default: pat = '1;
        endcase
        if (pos < m_on) return pat;
        return (m_mode == 2) ? ~pat : '0;
    endfunction

    function automatic void model_reset();
        m_active  = 0;
        m_in_done = 0;
        m_t       = 0;
    endfunction

    function automatic void model_step(input logic tick, input logic start, input logic stop);
        if (m_in_done) begin
            m_in_done = 0;
        end else if (!m_active) begin
            if (start && !stop) begin
                m_mode   = (int'(bus.i_mode) == 3) ? 0 : int'(bus.i_mode);
                m_on     = (bus.i_on_len  == 0) ? 1 : int'(bus.i_on_len);
                m_off    = (bus.i_off_len == 0) ? 1 : int'(bus.i_off_len);
                m_reps   = int'(bus.i_reps);
                m_t      = 0;
                m_active = 1;
            end
        end else if (stop) begin
            m_active = 0;
        end else if (tick) begin
            m_t++;
            if (m_reps != 0 && m_t == m_reps * (m_on + m_off)) begin
                m_active  = 0;
                m_in_done = 1;
            end
        end
    endfunction

    // ---------------- checks ----------------
    task automatic check(input string tag);
        logic [LED_W-1:0] el;
        el = exp_led();
        total++;
        assert (bus.o_led === el) else begin
            bad++;
            $error("FAIL %s led got=%h exp=%h t=%0t", tag, bus.o_led, el, $time);
        end
        total++;
        assert (bus.o_busy === logic'(m_active)) else begin
            bad++;
            $error("FAIL %s busy got=%b exp=%b t=%0t", tag, bus.o_busy, m_active, $time);
        end
        total++;
        assert (bus.o_done === logic'(m_in_done)) else begin
            bad++;
            $error("FAIL %s done got=%b exp=%b t=%0t", tag, bus.o_done, m_in_done, $time);
        end
    endtask

    // ---------------- driver ----------------
    task automatic cyc(input logic tick, input logic start, input logic stop, input string tag);
        bus.i_tick  = tick;
        bus.i_start = start;
        bus.i_stop  = stop;
        @(posedge i_clk);
        model_step(tick, start, stop);
        @(negedge i_clk);
        check(tag);
    endtask

    task automatic set_params(input int mode, input int on_len, input int off_len, input int reps);
        bus.i_mode    = 2'(mode);
        bus.i_on_len  = LEN_W'(on_len);
        bus.i_off_len = LEN_W'(off_len);
        bus.i_reps    = REP_W'(reps);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus.i_tick  = 1'b0;
        bus.i_start = 1'b0;
        bus.i_stop  = 1'b0;
        set_params(0, 1, 1, 0);
        model_reset();

        repeat (2) @(negedge i_clk);
        check("reset");
        i_rst = 1'b0;

        // Idle with ticks; start+stop together must not start.
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 1'b0, "idle_tick");
        cyc(1'b0, 1'b1, 1'b1, "start_stop");
        cyc(1'b0, 1'b0, 1'b0, "start_stop_after");

        // mode 0, on=2 off=1 reps=2.
        set_params(0, 2, 1, 2);
        cyc(1'b0, 1'b1, 1'b0, "m0_start");
        for (int i = 0; i < 7; i++) begin
            cyc(1'b1, 1'b0, 1'b0, "m0_tick");
            cyc(1'b0, 1'b0, 1'b0, "m0_gap");
        end

        // mode 1 walking, 9 reps with wrap.
        set_params(1, 1, 1, 9);
        cyc(1'b0, 1'b1, 1'b0, "m1_start");
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 1'b0, 1'b0, "m1_tick");
            cyc(1'b0, 1'b0, 1'b0, "m1_gap");
        end

        // mode 2 continuous, then stop coinciding with a tick.
        set_params(2, 1, 1, 0);
        cyc(1'b0, 1'b1, 1'b0, "m2_start");
        for (int i = 0; i < 11; i++) begin
            cyc(1'b1, 1'b0, 1'b0, "m2_tick");
            cyc(1'b0, 1'b0, 1'b0, "m2_gap");
        end
        cyc(1'b1, 1'b0, 1'b1, "m2_stop");
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, "m2_after_stop");

        // Zero lengths act as 1; start during ON and changed inputs are ignored.
        set_params(0, 0, 0, 1);
        cyc(1'b0, 1'b1, 1'b0, "zero_start");
        set_params(1, 5, 5, 3);
        cyc(1'b0, 1'b1, 1'b0, "zero_restart_ignored");
        cyc(1'b1, 1'b0, 1'b0, "zero_on_tick");
        cyc(1'b0, 1'b0, 1'b0, "zero_gap");
        cyc(1'b1, 1'b0, 1'b0, "zero_off_tick");
        cyc(1'b0, 1'b1, 1'b0, "zero_done_start_ignored");
        cyc(1'b0, 1'b0, 1'b0, "zero_idle");

        // Asynchronous reset mid-ON, then a fresh start.
        set_params(1, 3, 2, 2);
        cyc(1'b0, 1'b1, 1'b0, "ar_start");
        cyc(1'b1, 1'b0, 1'b0, "ar_tick");
        #2 i_rst = 1'b1;
        #1 model_reset();
        check("ar_immediate");
        @(negedge i_clk);
        check("ar_held");
        i_rst = 1'b0;
        cyc(1'b0, 1'b1, 1'b0, "ar_restart");
        for (int i = 0; i < 12; i++) cyc(1'b1, 1'b0, 1'b0, "ar_run");
        cyc(1'b0, 1'b0, 1'b0, "ar_idle");

        // Randomized sequences.
        for (int s = 0; s < 10; s++) begin
            set_params($urandom_range(0, 3), $urandom_range(0, 5),
                       $urandom_range(0, 5), $urandom_range(0, 3));
            cyc(1'b0, 1'b1, 1'b0, "rnd_start");
            for (int i = 0; i < 150; i++) begin
                cyc(logic'($urandom_range(0, 2) == 0),
                    logic'($urandom_range(0, 15) == 0),
                    logic'($urandom_range(0, 199) == 0), "rnd_run");
            end
            cyc(1'b0, 1'b0, 1'b1, "rnd_stop");
            cyc(1'b0, 1'b0, 1'b0, "rnd_idle");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute bound in case something stalls the stimulus thread.
    initial begin
        #500000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
